// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller.
// FSM state encodings, default operand width and a flag-sanity helper.
// The optional early-exit build is selected with SAR_EARLY_EXIT_EN.
package sar_search_pkg;

   // Default operand width; also the number of search steps.
   localparam int SAR_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // A healthy comparator asserts exactly one of EQ / A_GT_B / B_GT_A.
   function automatic logic flags_onehot(input logic eq_f,
                                         input logic gt_f,
                                         input logic lt_f);
      logic ok;
      case ({eq_f, gt_f, lt_f})
         3'b100, 3'b010, 3'b001: ok = 1'b1;
         default:                ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/sar_step.sv
// One successive-approximation step, purely combinational.
// Given the current trial, the bit under test and the comparator flags,
// produce the next trial/index, the value to publish if this step ends the
// search, and whether the search finishes or errors on this step.
// With SAR_EARLY_EXIT_EN defined, an EQ flag ends the search immediately.
module sar_step
   import sar_search_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH_DEF,
   parameter int IW    = $clog2(SAR_WIDTH_DEF)
) (
   input  logic [WIDTH-1:0] trial_i,
   input  logic [IW-1:0]    idx_i,
   input  logic             eq_i,
   input  logic             a_gt_b_i,
   input  logic             b_gt_a_i,
   output logic [WIDTH-1:0] trial_o,
   output logic [IW-1:0]    idx_o,
   output logic [WIDTH-1:0] result_o,
   output logic             fin_o,
   output logic             err_o
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] kept;
   logic             last;
   logic             bad_flags;

   // Decide the fate of bit k and prepare the probe for bit k-1.
   always_comb begin
      mask      = ONE << idx_i;
      last      = (idx_i == '0);
      bad_flags = !flags_onehot(eq_i, a_gt_b_i, b_gt_a_i);
      // A below the trial means bit k cannot be set; EQ and A_GT_B keep it.
      kept      = b_gt_a_i ? (trial_i & ~mask) : trial_i;
      // On the last step the trial register is left alone so it keeps
      // showing the final probe through DONE and IDLE.
      trial_o   = last ? trial_i : (kept | (mask >> 1));
      idx_o     = last ? idx_i : (idx_i - IW'(1));
      // Bad flags publish the probe as-is; otherwise the decided value.
      result_o  = bad_flags ? trial_i : kept;
      // A above every bit of the final probe is impossible for a sane comparator.
      err_o     = bad_flags | (last & a_gt_b_i);
      fin_o     = bad_flags | last;
`ifdef SAR_EARLY_EXIT_EN
      // Exact hit: the probe is A, nothing left to learn.
      if (eq_i) fin_o = 1'b1;
`endif
   end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives a trial operand to an
// external combinational magnitude comparator and reconstructs A MSB first.
// Optional build macro SAR_EARLY_EXIT_EN ends the search on the first EQ
// (handled inside sar_step); results are identical in both builds.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             eq,
   input  logic             a_gt_b,
   input  logic             b_gt_a,
   output logic [WIDTH-1:0] trial,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int               IW     = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] TRIAL0 = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [IW-1:0]    IDX0   = IW'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] trial_q;
   logic [WIDTH-1:0] result_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;

   logic [WIDTH-1:0] trial_d;
   logic [IW-1:0]    idx_d;
   logic [WIDTH-1:0] result_d;
   logic             fin_d;
   logic             err_d;

   sar_step #(
      .WIDTH (WIDTH),
      .IW    (IW)
   ) u_step (
      .trial_i  (trial_q),
      .idx_i    (idx_q),
      .eq_i     (eq),
      .a_gt_b_i (a_gt_b),
      .b_gt_a_i (b_gt_a),
      .trial_o  (trial_d),
      .idx_o    (idx_d),
      .result_o (result_d),
      .fin_o    (fin_d),
      .err_o    (err_d)
   );

   // Search FSM; every output is a register so the comparator sees a clean B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         trial_q  <= '0;
         result_q <= '0;
         idx_q    <= IDX0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_SEARCH;
                  trial_q <= TRIAL0;
                  idx_q   <= IDX0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            S_SEARCH: begin
               // start is deliberately not looked at here: no queuing.
               if (fin_d) begin
                  state_q  <= S_DONE;
                  result_q <= result_d;
                  err_q    <= err_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end else begin
                  trial_q <= trial_d;
                  idx_q   <= idx_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign trial  = trial_q;
   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule
